// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel gradient stage of the canny pipeline.
// Holds the direction codes, the tan(22.5 deg) ratio and the fixed pipeline latency.
package sobel_pkg;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_e;

    // tan(22.5 deg) is approximated as 13/32
    localparam int TAN_NUM = 13;
    localparam int TAN_DEN = 32;
    localparam int LAT     = 4;

    function automatic int grad_w(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/sobel_grad_win3x3_lb.sv
// Two line buffers plus a 3x3 shift window, with the column/row counters and the border rule.
// The tap at row 0 is the oldest line; the tap at column 2 is the newest pixel.
module win3x3_lb
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            pix_in,
    input  logic                         in_de,
    input  logic                         in_vs,
    output logic [2:0][2:0][DATA_W-1:0] taps,
    output logic                         win_valid
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [CW-1:0]     col_r;
    logic [15:0]       row_r;
    logic              de_d_r;
    logic              vs_d_r;
    logic [DATA_W-1:0] lb0_r [IMG_W];
    logic [DATA_W-1:0] lb1_r [IMG_W];

    logic              de_fall_s;
    logic              vs_rise_s;
    logic              col_ok_s;
    logic [AW-1:0]     addr_s;
    logic [DATA_W-1:0] lb0_q_s;
    logic [DATA_W-1:0] lb1_q_s;

    // Edge detection and line buffer read port; pixels beyond IMG_W never touch the RAM
    always_comb begin
        de_fall_s = de_d_r & ~in_de;
        vs_rise_s = in_vs & ~vs_d_r;
        col_ok_s  = (col_r < CW'(IMG_W));
        if (col_ok_s) begin
            addr_s = col_r[AW-1:0];
        end else begin
            addr_s = '0;
        end
        lb0_q_s = lb0_r[addr_s];
        lb1_q_s = lb1_r[addr_s];
    end

    // Column and row counters; a vs rising edge overrides a simultaneous de falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r  <= '0;
            row_r  <= 16'd0;
            de_d_r <= 1'b0;
            vs_d_r <= 1'b0;
        end else begin
            de_d_r <= in_de;
            vs_d_r <= in_vs;
            if (in_de) begin
                if (col_ok_s) begin
                    col_r <= col_r + CW'(1);
                end
            end else if (de_fall_s) begin
                col_r <= '0;
            end
            if (vs_rise_s) begin
                row_r <= 16'd0;
            end else if (de_fall_s && (row_r != 16'hFFFF)) begin
                row_r <= row_r + 16'd1;
            end
        end
    end

    // Line buffer storage; contents are never cleared because the border rule masks them
    always_ff @(posedge clk) begin
        if (in_de && col_ok_s) begin
            lb0_r[addr_s] <= pix_in;
            lb1_r[addr_s] <= lb0_q_s;
        end
    end

    // Window shift: the new right column is {two lines up, one line up, current pixel}
    always_ff @(posedge clk) begin
        if (rst) begin
            taps      <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= in_de & col_ok_s & (row_r >= 16'd2) & (col_r >= CW'(2));
            if (in_de) begin
                for (int r = 0; r < 3; r++) begin
                    taps[r][0] <= taps[r][1];
                    taps[r][1] <= taps[r][2];
                end
                taps[0][2] <= lb1_q_s;
                taps[1][2] <= lb0_q_s;
                taps[2][2] <= pix_in;
            end
        end
    end

endmodule

// File: rtl/sobel_grad.sv
// Sobel gradient stage: 3x3 window, Gx/Gy, scaled saturated magnitude, quantised direction
// and thresholded edge flag, with hs/vs/de delayed by LAT to stay aligned.
module sobel_grad
    import sobel_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 640,
    parameter int MAG_SHIFT = 3,
    parameter int GRAD_W    = grad_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              in_hs,
    input  logic              in_vs,
    input  logic              in_de,
    input  logic [DATA_W-1:0] thresh,
    output logic [GRAD_W-1:0] gx_out,
    output logic [GRAD_W-1:0] gy_out,
    output logic [DATA_W-1:0] mag_out,
    output logic [1:0]        dir_out,
    output logic              edge_out,
    output logic              out_hs,
    output logic              out_vs,
    output logic              out_de
);

    localparam int SW = DATA_W + 2;
    localparam int DW = GRAD_W + 6;
    localparam logic [GRAD_W-1:0] MAG_MAX = {{(GRAD_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    function automatic logic [SW-1:0] wsum(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic [DATA_W-1:0] c);
        return SW'(a) + SW'(b) + SW'(b) + SW'(c);
    endfunction

    logic [2:0][2:0][DATA_W-1:0] taps_s;
    logic                        v1_s;

    logic [SW-1:0]     sl_r, sr_r, st_r, sb_r;
    logic              v2_r;
    logic [GRAD_W-1:0] gx3_r, gy3_r, ax3_r, ay3_r;
    logic              v3_r;
    logic [LAT-1:0]    hs_d_r, vs_d_r, de_d_r;

    logic [GRAD_W-1:0] gx_s, gy_s, ax_s, ay_s;
    logic [GRAD_W-1:0] sum_s, shr_s;
    logic [DATA_W-1:0] mag_s;
    logic [DW-1:0]     ax_den_s, ay_den_s, ax_num_s, ay_num_s;
    dir_e              dir_s;
    logic              edge_s;

    win3x3_lb #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .pix_in   (pix_in),
        .in_de    (in_de),
        .in_vs    (in_vs),
        .taps     (taps_s),
        .win_valid(v1_s)
    );

    // Stage 2: weighted column (left/right) and row (top/bottom) sums
    always_ff @(posedge clk) begin
        if (rst) begin
            sl_r <= '0;
            sr_r <= '0;
            st_r <= '0;
            sb_r <= '0;
            v2_r <= 1'b0;
        end else begin
            sl_r <= wsum(taps_s[0][0], taps_s[1][0], taps_s[2][0]);
            sr_r <= wsum(taps_s[0][2], taps_s[1][2], taps_s[2][2]);
            st_r <= wsum(taps_s[0][0], taps_s[0][1], taps_s[0][2]);
            sb_r <= wsum(taps_s[2][0], taps_s[2][1], taps_s[2][2]);
            v2_r <= v1_s;
        end
    end

    // Signed differences and their absolute values; one extra bit means no overflow
    always_comb begin
        gx_s = GRAD_W'(sr_r) - GRAD_W'(sl_r);
        gy_s = GRAD_W'(sb_r) - GRAD_W'(st_r);
        if (gx_s[GRAD_W-1]) begin
            ax_s = -gx_s;
        end else begin
            ax_s = gx_s;
        end
        if (gy_s[GRAD_W-1]) begin
            ay_s = -gy_s;
        end else begin
            ay_s = gy_s;
        end
    end

    // Stage 3 register
    always_ff @(posedge clk) begin
        if (rst) begin
            gx3_r <= '0;
            gy3_r <= '0;
            ax3_r <= '0;
            ay3_r <= '0;
            v3_r  <= 1'b0;
        end else begin
            gx3_r <= gx_s;
            gy3_r <= gy_s;
            ax3_r <= ax_s;
            ay3_r <= ay_s;
            v3_r  <= v2_r;
        end
    end

    // Magnitude, direction sector and edge decision
    always_comb begin
        sum_s    = ax3_r + ay3_r;
        shr_s    = sum_s >> MAG_SHIFT;
        ax_den_s = DW'(ax3_r) * DW'(TAN_DEN);
        ay_den_s = DW'(ay3_r) * DW'(TAN_DEN);
        ax_num_s = DW'(ax3_r) * DW'(TAN_NUM);
        ay_num_s = DW'(ay3_r) * DW'(TAN_NUM);
        if (shr_s > MAG_MAX) begin
            mag_s = {DATA_W{1'b1}};
        end else begin
            mag_s = shr_s[DATA_W-1:0];
        end
        if (ay_den_s <= ax_num_s) begin
            dir_s = DIR_0;
        end else if (ax_den_s <= ay_num_s) begin
            dir_s = DIR_90;
        end else if (gx3_r[GRAD_W-1] == gy3_r[GRAD_W-1]) begin
            dir_s = DIR_45;
        end else begin
            dir_s = DIR_135;
        end
        edge_s = (mag_s > thresh);
    end

    // Stage 4 output register; invalid windows are forced to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            gx_out   <= '0;
            gy_out   <= '0;
            mag_out  <= '0;
            dir_out  <= 2'd0;
            edge_out <= 1'b0;
        end else if (v3_r) begin
            gx_out   <= gx3_r;
            gy_out   <= gy3_r;
            mag_out  <= mag_s;
            dir_out  <= dir_s;
            edge_out <= edge_s;
        end else begin
            gx_out   <= '0;
            gy_out   <= '0;
            mag_out  <= '0;
            dir_out  <= 2'd0;
            edge_out <= 1'b0;
        end
    end

    // Sync delay lines matching the data latency
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d_r <= '0;
            vs_d_r <= '0;
            de_d_r <= '0;
        end else begin
            hs_d_r <= {hs_d_r[LAT-2:0], in_hs};
            vs_d_r <= {vs_d_r[LAT-2:0], in_vs};
            de_d_r <= {de_d_r[LAT-2:0], in_de};
        end
    end

    assign out_hs = hs_d_r[LAT-1];
    assign out_vs = vs_d_r[LAT-1];
    assign out_de = de_d_r[LAT-1];

endmodule

// File: tb/tb_sobel_grad.sv
// Directed bench for sobel_grad: two instances (default, and IMG_W=16 with MAG_SHIFT=0)
// fed the same frames; outputs are captured per output row/column and checked per scenario.
module tb_sobel_grad;

    logic        clk = 1'b0;
    logic        rst, in_hs, in_vs, in_de;
    logic [7:0]  pix_in, thresh;

    logic [10:0] gx0, gy0, gx1, gy1;
    logic [7:0]  mag0, mag1;
    logic [1:0]  dir0, dir1;
    logic        edge0, edge1, hs0, vs0, de0, hs1, vs1, de1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sobel_grad #(.DATA_W(8), .IMG_W(640), .MAG_SHIFT(3)) dut0 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .thresh(thresh), .gx_out(gx0), .gy_out(gy0), .mag_out(mag0), .dir_out(dir0),
        .edge_out(edge0), .out_hs(hs0), .out_vs(vs0), .out_de(de0));

    sobel_grad #(.DATA_W(8), .IMG_W(16), .MAG_SHIFT(0)) dut1 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .thresh(thresh), .gx_out(gx1), .gy_out(gy1), .mag_out(mag1), .dir_out(dir1),
        .edge_out(edge1), .out_hs(hs1), .out_vs(vs1), .out_de(de1));

    // Capture store indexed by output row/column
    logic [10:0] c_gx0 [8][20];
    logic [10:0] c_gy0 [8][20];
    logic [7:0]  c_mag0 [8][20];
    logic [1:0]  c_dir0 [8][20];
    logic        c_edge0 [8][20];
    logic [10:0] c_gx1 [8][20];
    logic [7:0]  c_mag1 [8][20];
    logic        c_edge1 [8][20];
    int orow = 0, ocol = 0, n_cap = 0;
    logic ovs_prev = 1'b0, ode_prev = 1'b0;

    // Sync alignment monitor
    logic [3:0] h_de = 4'd0, h_hs = 4'd0, h_vs = 4'd0;
    logic sync_en = 1'b0;
    int   sync_bad = 0, sync_cnt = 0;

    always @(negedge clk) begin
        if (vs0 && !ovs_prev) begin
            orow = 0;
            ocol = 0;
        end
        if (de0) begin
            if (orow < 8 && ocol < 20) begin
                c_gx0[orow][ocol]   = gx0;
                c_gy0[orow][ocol]   = gy0;
                c_mag0[orow][ocol]  = mag0;
                c_dir0[orow][ocol]  = dir0;
                c_edge0[orow][ocol] = edge0;
                c_gx1[orow][ocol]   = gx1;
                c_mag1[orow][ocol]  = mag1;
                c_edge1[orow][ocol] = edge1;
            end
            ocol++;
            n_cap++;
        end else if (ode_prev) begin
            orow++;
            ocol = 0;
        end
        ovs_prev = vs0;
        ode_prev = de0;
        if (sync_en) begin
            sync_cnt++;
            if (de0 !== h_de[3] || hs0 !== h_hs[3] || vs0 !== h_vs[3]) sync_bad++;
        end
        h_de = {h_de[2:0], in_de};
        h_hs = {h_hs[2:0], in_hs};
        h_vs = {h_vs[2:0], in_vs};
    end

    function automatic logic [7:0] pix_val(input int mode, input int r, input int c);
        int v;
        case (mode)
            0:       v = 100;
            1:       v = (c >= 8) ? 255 : 0;
            2:       v = (r >= 4) ? 255 : 0;
            3:       v = 10 * (r + c);
            4:       v = 10 * (r + 15 - c);
            5:       v = (c >= 16) ? 255 : 0;
            default: v = 0;
        endcase
        return v[7:0];
    endfunction

    function automatic logic [32:0] cap0(input int r, input int c);
        return {c_gx0[r][c], c_gy0[r][c], c_mag0[r][c], c_dir0[r][c], c_edge0[r][c]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 20; c++) begin
                c_gx0[r][c] = 'x; c_gy0[r][c] = 'x; c_mag0[r][c] = 'x; c_dir0[r][c] = 'x;
                c_edge0[r][c] = 1'bx; c_gx1[r][c] = 'x; c_mag1[r][c] = 'x; c_edge1[r][c] = 1'bx;
            end
        end
        n_cap = 0;
    endtask

    task automatic send_frame(input int mode, input int rows, input int cols);
        in_vs = 1'b1; tick(); tick(); in_vs = 1'b0;
        repeat (4) tick();
        for (int r = 0; r < rows; r++) begin
            in_hs = 1'b1; tick(); in_hs = 1'b0; tick();
            for (int c = 0; c < cols; c++) begin
                in_de  = 1'b1;
                pix_in = pix_val(mode, r, c);
                tick();
            end
            in_de  = 1'b0;
            pix_in = 8'd0;
            repeat (6) tick();
        end
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0; pix_in = 8'd0; thresh = 8'd0;
        repeat (3) tick();
        n_cmp++;
        if ({gx0, gy0, mag0, dir0, edge0} !== 33'd0) begin
            n_bad++; $display("FAIL reset_data got %h want 0", {gx0, gy0, mag0, dir0, edge0});
        end
        n_cmp++;
        if ({hs0, vs0, de0} !== 3'd0) begin
            n_bad++; $display("FAIL reset_sync got %b want 000", {hs0, vs0, de0});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_flat();
        thresh = 8'd10;
        clear_cap();
        sync_bad = 0; sync_cnt = 0; sync_en = 1'b1;
        send_frame(0, 8, 16);
        sync_en = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                n_cmp++;
                if (cap0(r, c) !== 33'd0) begin
                    n_bad++; $display("FAIL flat r%0d c%0d got %h want 0", r, c, cap0(r, c));
                end
            end
        end
        n_cmp++;
        if (n_cap !== 128) begin
            n_bad++; $display("FAIL flat_de_count got %0d want 128", n_cap);
        end
        n_cmp++;
        if (sync_bad !== 0 || sync_cnt < 100) begin
            n_bad++; $display("FAIL sync_delay4 bad %0d of %0d want 0", sync_bad, sync_cnt);
        end
    endtask

    task automatic test_step();
        logic [32:0] e0;
        logic [8:0]  e1;
        logic        hit;
        thresh = 8'd50;
        clear_cap();
        send_frame(1, 8, 16);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                hit = (r >= 2) && (c == 8 || c == 9);
                e0  = hit ? {11'h3FC, 11'h000, 8'd127, 2'd0, 1'b1} : 33'd0;
                e1  = hit ? {8'd255, 1'b1} : 9'd0;
                n_cmp++;
                if (cap0(r, c) !== e0) begin
                    n_bad++; $display("FAIL step r%0d c%0d got %h want %h", r, c, cap0(r, c), e0);
                end
                n_cmp++;
                if ({c_mag1[r][c], c_edge1[r][c]} !== e1) begin
                    n_bad++; $display("FAIL step_sat r%0d c%0d got %h want %h", r, c,
                                      {c_mag1[r][c], c_edge1[r][c]}, e1);
                end
            end
        end
    endtask

    task automatic test_transposed();
        logic [32:0] e0;
        thresh = 8'd50;
        clear_cap();
        send_frame(2, 8, 16);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                e0 = ((r == 4 || r == 5) && c >= 2) ? {11'h000, 11'h3FC, 8'd127, 2'd2, 1'b1} : 33'd0;
                n_cmp++;
                if (cap0(r, c) !== e0) begin
                    n_bad++; $display("FAIL vstep r%0d c%0d got %h want %h", r, c, cap0(r, c), e0);
                end
            end
        end
    endtask

    task automatic test_ramp(input int mode);
        logic [32:0] e0;
        thresh = 8'd10;
        clear_cap();
        send_frame(mode, 8, 16);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                if (r < 2 || c < 2)
                    e0 = 33'd0;
                else if (mode == 3)
                    e0 = {11'h050, 11'h050, 8'd20, 2'd1, 1'b1};
                else
                    e0 = {11'h7B0, 11'h050, 8'd20, 2'd3, 1'b1};
                n_cmp++;
                if (cap0(r, c) !== e0) begin
                    n_bad++; $display("FAIL ramp%0d r%0d c%0d got %h want %h", mode, r, c, cap0(r, c), e0);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [8:0] e1;
        logic       hit;
        thresh = 8'd255;
        clear_cap();
        send_frame(1, 8, 16);
        for (int r = 2; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                hit = (c == 8 || c == 9);
                e1  = hit ? {8'd255, 1'b0} : 9'd0;
                n_cmp++;
                if ({c_mag1[r][c], c_edge1[r][c]} !== e1) begin
                    n_bad++; $display("FAIL sat_thresh r%0d c%0d got %h want %h", r, c,
                                      {c_mag1[r][c], c_edge1[r][c]}, e1);
                end
                n_cmp++;
                if (c_edge0[r][c] !== 1'b0) begin
                    n_bad++; $display("FAIL edge_thresh255 r%0d c%0d got %b want 0", r, c, c_edge0[r][c]);
                end
            end
        end
    endtask

    task automatic test_long_line();
        logic [10:0] e0;
        thresh = 8'd50;
        clear_cap();
        send_frame(5, 8, 18);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 18; c++) begin
                e0 = (r >= 2 && c >= 16) ? 11'h3FC : 11'h000;
                n_cmp++;
                if (c_gx0[r][c] !== e0) begin
                    n_bad++; $display("FAIL long_wide r%0d c%0d got %h want %h", r, c, c_gx0[r][c], e0);
                end
                n_cmp++;
                if (c_gx1[r][c] !== 11'h000) begin
                    n_bad++; $display("FAIL long_border r%0d c%0d got %h want 0", r, c, c_gx1[r][c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        thresh = 8'd10;
        in_vs = 1'b1; tick(); tick(); in_vs = 1'b0;
        repeat (4) tick();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 16; c++) begin
                in_de = 1'b1; pix_in = pix_val(3, r, c); tick();
            end
            in_de = 1'b0; repeat (6) tick();
        end
        for (int c = 0; c < 6; c++) begin
            in_de = 1'b1; pix_in = pix_val(3, 5, c); tick();
        end
        n_cmp++;
        if (gx0 !== 11'h050) begin
            n_bad++; $display("FAIL pre_reset_gx got %h want 050", gx0);
        end
        pix_in = pix_val(3, 5, 6);
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({gx0, gy0, mag0, dir0, edge0, de0} !== 34'd0) begin
            n_bad++; $display("FAIL mid_reset got %h want 0", {gx0, gy0, mag0, dir0, edge0, de0});
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pix_in = pix_val(3, 5, 7 + k);
            tick();
            n_cmp++;
            if (de0 !== 1'b0) begin
                n_bad++; $display("FAIL post_reset_de k%0d got %b want 0", k, de0);
            end
        end
        pix_in = pix_val(3, 5, 10);
        tick();
        n_cmp++;
        if ({de0, gx0, mag0} !== {1'b1, 11'h000, 8'd0}) begin
            n_bad++; $display("FAIL post_reset_resume got %h want %h", {de0, gx0, mag0}, {1'b1, 11'h000, 8'd0});
        end
        for (int c = 11; c < 16; c++) begin
            pix_in = pix_val(3, 5, c); tick();
        end
        in_de = 1'b0; pix_in = 8'd0;
        repeat (8) tick();
        clear_cap();
        send_frame(3, 8, 16);
        n_cmp++;
        if (cap0(1, 5) !== 33'd0) begin
            n_bad++; $display("FAIL after_reset_border got %h want 0", cap0(1, 5));
        end
        n_cmp++;
        if (cap0(2, 2) !== {11'h050, 11'h050, 8'd20, 2'd1, 1'b1}) begin
            n_bad++; $display("FAIL after_reset_interior got %h want %h", cap0(2, 2),
                              {11'h050, 11'h050, 8'd20, 2'd1, 1'b1});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_flat();
        test_step();
        test_transposed();
        test_ramp(3);
        test_ramp(4);
        test_saturation();
        test_long_line();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
